// File: rtl/cl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cl_pkg
// Description : Shared types and constants for the CameraLink LVDS transmit
//               sequencer: link state encoding, word size and the default
//               clock-lane, training and idle words.
// Revision    : 1.0 - initial release
// ============================================================================
package cl_pkg;

    // Bits carried per lane per pixel-clock period (7:1 serialisation).
    localparam int unsigned CL_BITS_PER_WORD = 7;

    // Default lane words, all sent MSB first.
    localparam logic [CL_BITS_PER_WORD-1:0] CL_CLK_PATTERN   = 7'b1100011;
    localparam logic [CL_BITS_PER_WORD-1:0] CL_TRAIN_PATTERN = 7'b1010101;
    localparam logic [CL_BITS_PER_WORD-1:0] CL_IDLE_WORD     = 7'b0000000;

    // Link sequencer state.
    typedef enum logic [1:0] {
        OFF   = 2'd0,
        TRAIN = 2'd1,
        RUN   = 2'd2
    } cl_state_e;

endpackage : cl_pkg
`default_nettype wire

// File: rtl/cl_lane_ser.sv
`default_nettype none
// ============================================================================
// Module      : cl_lane_ser
// Description : One 7-bit parallel-load, MSB-first shift register feeding a
//               single LVDS lane. Load has priority over shift; shifting
//               back-fills with zero.
// Ports       : clk, rst   - bit clock, asynchronous active-high reset
//               i_load     - capture i_din this cycle
//               i_shift    - advance one bit toward the MSB
//               i_din      - parallel word
//               o_dout     - registered serial bit (MSB of the register)
// Revision    : 1.0 - initial release
// ============================================================================
module cl_lane_ser
    import cl_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_load,
    input  logic                        i_shift,
    input  logic [CL_BITS_PER_WORD-1:0] i_din,
    output logic                        o_dout
);

    logic [CL_BITS_PER_WORD-1:0] sreg_q;
    logic [CL_BITS_PER_WORD-1:0] sreg_d;

    always_comb begin
        sreg_d = sreg_q;
        if (i_load) begin
            sreg_d = i_din;
        end else if (i_shift) begin
            sreg_d = {sreg_q[CL_BITS_PER_WORD-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_q <= '0;
        end else begin
            sreg_q <= sreg_d;
        end
    end

    assign o_dout = sreg_q[CL_BITS_PER_WORD-1];

endmodule : cl_lane_ser
`default_nettype wire

// File: rtl/cl_lvds_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cl_lvds_tx_ctrl
// Description : CameraLink transmit LVDS sequencer. Accepts one 7-bit word per
//               lane through a valid/ready handshake, serialises MSB first,
//               drives the forwarded-clock lane pattern and runs a training
//               phase before (and on request during) normal operation.
// Ports       : clk        - serial bit clock (7x pixel rate)
//               rst        - asynchronous active-high reset
//               en         - link enable
//               train_req  - retraining request, latched while in RUN
//               word_data  - lane k word at [7k+6:7k]
//               word_valid - word_data valid
//               word_ready - word taken this cycle if word_valid is high
//               ser_data   - serial bit per data lane
//               ser_clk    - serial forwarded-clock lane bit
//               trained    - high while in RUN
//               underrun   - pulses on the boundary an idle word is inserted
// Revision    : 1.0 - initial release
// ============================================================================
module cl_lvds_tx_ctrl
    import cl_pkg::*;
#(
    parameter int unsigned                 NUM_LANES     = 4,
    parameter int unsigned                 TRAIN_WORDS   = 64,
    parameter logic [CL_BITS_PER_WORD-1:0] CLK_PATTERN   = CL_CLK_PATTERN,
    parameter logic [CL_BITS_PER_WORD-1:0] TRAIN_PATTERN = CL_TRAIN_PATTERN,
    parameter logic [CL_BITS_PER_WORD-1:0] IDLE_WORD     = CL_IDLE_WORD
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  en,
    input  logic                                  train_req,
    input  logic [CL_BITS_PER_WORD*NUM_LANES-1:0] word_data,
    input  logic                                  word_valid,
    output logic                                  word_ready,
    output logic [NUM_LANES-1:0]                  ser_data,
    output logic                                  ser_clk,
    output logic                                  trained,
    output logic                                  underrun
);

    localparam int unsigned c_word_w     = CL_BITS_PER_WORD * NUM_LANES;
    localparam logic [2:0]  c_last_bit   = 3'(CL_BITS_PER_WORD - 1);
    localparam logic [15:0] c_train_last = 16'(TRAIN_WORDS - 1);

    cl_state_e     state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [15:0]   train_cnt_q, train_cnt_d;
    logic          pend_q, pend_d;
    logic          trained_q, trained_d;

    logic                        w_boundary;
    logic                        w_pend_eff;
    logic                        w_load;
    logic                        w_shift;
    logic [c_word_w-1:0]         w_lane_word;
    logic [CL_BITS_PER_WORD-1:0] w_clk_word;
    logic                        w_word_ready;
    logic                        w_underrun;

    // ------------------------------------------------------------------------
    // Next-state, counters and handshake
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        train_cnt_d  = train_cnt_q;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_lane_word  = '0;
        w_clk_word   = CLK_PATTERN;
        w_word_ready = 1'b0;
        w_underrun   = 1'b0;

        w_boundary = (bit_cnt_q == c_last_bit);
        // A request arriving on the boundary cycle itself is serviced at
        // that boundary rather than being held for a further word.
        w_pend_eff = pend_q | ((state_q == RUN) & train_req);
        pend_d     = w_pend_eff;

        case (state_q)
            OFF: begin
                // Keep every lane register cleared while idle so a restart
                // never exposes stale bits.
                bit_cnt_d  = '0;
                pend_d     = 1'b0;
                w_load     = 1'b1;
                w_clk_word = '0;
                if (en) begin
                    state_d     = TRAIN;
                    train_cnt_d = '0;
                    w_lane_word = {NUM_LANES{TRAIN_PATTERN}};
                    w_clk_word  = CLK_PATTERN;
                end
            end

            TRAIN, RUN: begin
                bit_cnt_d = w_boundary ? 3'd0 : bit_cnt_q + 3'd1;
                w_shift   = ~w_boundary;
                if (w_boundary) begin
                    w_load = 1'b1;
                    if (!en) begin
                        state_d    = OFF;
                        pend_d     = 1'b0;
                        w_clk_word = '0;
                    end else if ((state_q == RUN) && w_pend_eff) begin
                        state_d     = TRAIN;
                        pend_d      = 1'b0;
                        train_cnt_d = '0;
                        w_lane_word = {NUM_LANES{TRAIN_PATTERN}};
                    end else if ((state_q == TRAIN) && (train_cnt_q != c_train_last)) begin
                        train_cnt_d = train_cnt_q + 16'd1;
                        w_lane_word = {NUM_LANES{TRAIN_PATTERN}};
                    end else begin
                        // Last training word or a normal RUN boundary:
                        // fetch the next word from the handshake.
                        state_d      = RUN;
                        w_word_ready = 1'b1;
                        if (word_valid) begin
                            w_lane_word = word_data;
                        end else begin
                            w_lane_word = {NUM_LANES{IDLE_WORD}};
                            w_underrun  = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = OFF;
            end
        endcase

        trained_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= OFF;
            bit_cnt_q   <= '0;
            train_cnt_q <= '0;
            pend_q      <= 1'b0;
            trained_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            train_cnt_q <= train_cnt_d;
            pend_q      <= pend_d;
            trained_q   <= trained_d;
        end
    end

    // ------------------------------------------------------------------------
    // Lane serialisers: NUM_LANES data lanes plus the forwarded clock lane
    // ------------------------------------------------------------------------
    generate
        for (genvar k = 0; k < NUM_LANES; k++) begin : g_lanes
            cl_lane_ser u_data_ser (
                .clk     (clk),
                .rst     (rst),
                .i_load  (w_load),
                .i_shift (w_shift),
                .i_din   (w_lane_word[CL_BITS_PER_WORD*k +: CL_BITS_PER_WORD]),
                .o_dout  (ser_data[k])
            );
        end
    endgenerate

    cl_lane_ser u_clk_ser (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_din   (w_clk_word),
        .o_dout  (ser_clk)
    );

    assign word_ready = w_word_ready;
    assign underrun   = w_underrun;
    assign trained    = trained_q;

endmodule : cl_lvds_tx_ctrl
`default_nettype wire

// File: tb/tb_cl_lvds_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cl_lvds_tx_ctrl
// Description : Self-checking bench for cl_lvds_tx_ctrl (4 lanes, 4 training
//               words). Each driven cycle queues the outputs expected for
//               that cycle; a monitor pops and compares them mid-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cl_lvds_tx_ctrl;

    localparam int NL = 4;
    localparam int WW = 7 * NL;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          train_req = 1'b0;
    logic [WW-1:0] word_data = '0;
    logic          word_valid = 1'b0;
    logic          word_ready;
    logic [NL-1:0] ser_data;
    logic          ser_clk;
    logic          trained;
    logic          underrun;

    cl_lvds_tx_ctrl #(
        .NUM_LANES   (NL),
        .TRAIN_WORDS (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .train_req  (train_req),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .ser_data   (ser_data),
        .ser_clk    (ser_clk),
        .trained    (trained),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NL-1:0] d;
        logic          c;
        logic          t;
        logic          r;
        logic          u;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc_no = 0;

    logic [6:0]    clkp    = 7'b1100011;
    logic [WW-1:0] w_train = {4{7'b1010101}};
    logic [WW-1:0] w_zero  = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc_no, got, exp);
        end
    endtask

    function automatic logic [WW-1:0] pack4(input logic [6:0] l0, input logic [6:0] l1,
                                            input logic [6:0] l2, input logic [6:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    // One clock cycle: drive inputs just after the edge, queue expectations.
    task automatic cyc(input string tag, input logic r, input logic e, input logic req,
                       input logic v, input logic [WW-1:0] d, input logic [NL-1:0] ed,
                       input logic ec, input logic et, input logic er, input logic eu);
        exp_t x;
        @(posedge clk);
        #1;
        rst        = r;
        en         = e;
        train_req  = req;
        word_valid = v;
        word_data  = d;
        x.d = ed; x.c = ec; x.t = et; x.r = er; x.u = eu;
        exp_q.push_back(x);
        tag_q.push_back(tag);
    endtask

    // Seven cycles covering one lane word. ew: word expected on the lanes;
    // act: clock lane running; erdy/eunr: expected on the boundary cycle.
    // req_at / en_off_at / rst_at: bit position for those events (-1 none).
    task automatic send_word(input string tag, input logic [WW-1:0] ew, input logic act,
                             input logic et, input logic erdy, input logic eunr,
                             input logic vld, input logic [WW-1:0] dat,
                             input int req_at, input int en_off_at, input int rst_at);
        logic          live;
        logic          e_drv;
        logic [NL-1:0] ed;
        for (int n = 0; n < 7; n++) begin
            live  = (rst_at < 0) || (n < rst_at);
            e_drv = !((en_off_at >= 0) && (n >= en_off_at));
            for (int k = 0; k < NL; k++) begin
                ed[k] = live ? ew[7*k + 6 - n] : 1'b0;
            end
            cyc(tag, !live, e_drv, (n == req_at), vld, dat, ed,
                live & act & clkp[6-n], live & et,
                live & erdy & (n == 6), live & eunr & (n == 6));
        end
    endtask

    task automatic train_phase(input string tag, input logic [WW-1:0] first_run);
        for (int w = 0; w < 4; w++) begin
            // Valid is held throughout; only the final boundary may accept.
            send_word(tag, w_train, 1'b1, 1'b0, (w == 3), 1'b0, 1'b1,
                      (w == 3) ? first_run : ~first_run,
                      (w == 1) ? 3 : -1, -1, -1);
        end
    endtask

    exp_t  m_e;
    string m_t;
    always @(negedge clk) begin
        cyc_no++;
        if (exp_q.size() > 0) begin
            m_e = exp_q.pop_front();
            m_t = tag_q.pop_front();
            chk({m_t, " ser_data"},   32'(ser_data),   32'(m_e.d));
            chk({m_t, " ser_clk"},    32'(ser_clk),    32'(m_e.c));
            chk({m_t, " trained"},    32'(trained),    32'(m_e.t));
            chk({m_t, " word_ready"}, 32'(word_ready), 32'(m_e.r));
            chk({m_t, " underrun"},   32'(underrun),   32'(m_e.u));
        end
    end

    initial begin
        logic [WW-1:0] w1, w2, w3, w4, w5, w6, w7;
        w1 = pack4(7'h5A, 7'h11, 7'h22, 7'h7F);
        w2 = pack4(7'h33, 7'h0F, 7'h70, 7'h01);
        w3 = pack4(7'h4C, 7'h2B, 7'h55, 7'h40);
        w4 = pack4(7'h66, 7'h19, 7'h3C, 7'h08);
        w5 = pack4(7'h71, 7'h0E, 7'h2A, 7'h15);
        w6 = pack4(7'h6D, 7'h12, 7'h77, 7'h03);
        w7 = pack4(7'h1E, 7'h61, 7'h05, 7'h5F);

        // Reset and idle OFF state.
        cyc("reset", 1'b1, 1'b0, 1'b0, 1'b0, w_zero, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("reset", 1'b1, 1'b1, 1'b0, 1'b1, w1,     '0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("off",   1'b0, 1'b0, 1'b0, 1'b1, w1,     '0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("off",   1'b0, 1'b0, 1'b1, 1'b1, w1,     '0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Enable: one OFF cycle, four training words, then RUN.
        cyc("enable", 1'b0, 1'b1, 1'b0, 1'b1, w1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        train_phase("train1", w1);

        // Back-to-back words, then one underrun boundary.
        send_word("run_w1",   w1,     1'b1, 1'b1, 1'b1, 1'b0, 1'b1, w2, -1, -1, -1);
        send_word("run_w2",   w2,     1'b1, 1'b1, 1'b1, 1'b1, 1'b0, w3, -1, -1, -1);
        send_word("run_idle", w_zero, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, w3, -1, -1, -1);

        // Retrain request mid-word: word completes, nothing accepted.
        send_word("run_w3_req", w3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, w7, 2, -1, -1);
        train_phase("retrain", w4);
        send_word("run_w4_off", w4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, w7, 3, 3, -1);

        // OFF after disable with simultaneous request; re-enable must run a
        // normal training and then accept the first RUN word.
        send_word("off2", w_zero, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, w7, 1, 0, -1);
        cyc("enable2", 1'b0, 1'b1, 1'b0, 1'b1, w5, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        train_phase("train2", w5);

        // Reset in the middle of a RUN word.
        send_word("run_w5_rst", w5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, w7, -1, -1, 4);
        cyc("enable3", 1'b0, 1'b1, 1'b0, 1'b1, w6, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        train_phase("train3", w6);
        send_word("run_w6",   w6,     1'b1, 1'b1, 1'b1, 1'b1, 1'b0, w7, -1, -1, -1);
        send_word("run_last", w_zero, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, w7, -1, 0, -1);
        cyc("off3", 1'b0, 1'b0, 1'b0, 1'b0, w_zero, '0, 1'b0, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_cl_lvds_tx_ctrl
`default_nettype wire

// File: doc/cl_lvds_tx_ctrl.md
Name: cl_lvds_tx_ctrl

Overview:
Sequencer for the CameraLink transmit LVDS lanes. It accepts 7-bit-per-lane words through a valid/ready handshake and serialises them MSB-first, one bit per clock. It also generates the forwarded-clock lane pattern and runs a link-training phase. Its single-ended outputs drive one differential output buffer per lane (data lanes plus clock lane) at the top level.

Parameters:
NUM_LANES, 4, number of serial data lanes
TRAIN_WORDS, 64, training words sent before entering RUN (range 1..65535)
CLK_PATTERN, 7'b1100011, forwarded-clock lane word, repeated every word
TRAIN_PATTERN, 7'b1010101, word sent on every data lane during training
IDLE_WORD, 7'b0000000, word sent per lane on underrun

Ports:
clk  input  1  serial bit clock (7x pixel rate)
rst  input  1  asynchronous, active-high reset
en  input  1  link enable
train_req  input  1  request retraining; level-sampled, latched until serviced
word_data  input  7*NUM_LANES  lane k = word_data[7k+6:7k]
word_valid  input  1  word_data valid
word_ready  output  1  word accepted this cycle when word_valid=1
ser_data  output  NUM_LANES  serial bit per data lane, to the differential output buffers
ser_clk  output  1  serial forwarded-clock lane bit
trained  output  1  high while in RUN
underrun  output  1  1-cycle pulse when IDLE_WORD is inserted

Behaviour:
- Reset (async assert, sync release): state=OFF; bit_cnt=0; shift regs=0; ser_data=0; ser_clk=0; word_ready=0; trained=0; underrun=0; pending train flag=0.
- bit_cnt runs 0..6 and wraps in TRAIN and RUN. It is held at 0 in OFF. Boundary = cycle with bit_cnt==6.
- Bit order: at bit_cnt=n, the output is bit (6-n) of the current word, so MSB goes first.
- ser_clk = CLK_PATTERN[6-bit_cnt] in TRAIN and RUN, 0 in OFF. All outputs are registered.
- States:
  - OFF: outputs 0. When en=1, the next cycle enters TRAIN with bit_cnt=0, TRAIN_PATTERN loaded, and the train word counter cleared.
  - TRAIN: every lane sends TRAIN_PATTERN. The word counter increments at each boundary. At the boundary completing word TRAIN_WORDS, the next state is RUN, and the first RUN word is loaded from the handshake using RUN load rules.
  - RUN: word_ready=1 only on boundary cycles, otherwise 0.
    - At a boundary with word_valid=1, word_data is loaded and its first bit appears the next cycle (1-cycle latency).
    - At a boundary with word_valid=0, IDLE_WORD is loaded and underrun pulses for 1 cycle, coincident with the boundary.
- train_req: any cycle in RUN sets the pending flag. At the next boundary: state goes to TRAIN, the flag clears, the counter clears, and word_ready=0 on that boundary. train_req during TRAIN is ignored and does not extend training.
- en=0 in TRAIN or RUN: the current word completes. At the boundary, state goes to OFF and all outputs are 0 from the next cycle. word_ready=0 on that boundary.
- Simultaneous events at a boundary: en=0 beats a pending train_req, which beats the RUN load. Both en=0 and train_req clear the pending flag.
- trained is asserted the cycle RUN's first bit is output and deasserted the cycle the state leaves RUN.
- word_data is only sampled when word_valid & word_ready. Upstream may drop valid at any time.
- Reset mid-word: outputs go to 0 immediately. After release, the block restarts from OFF; a partial word is never resumed.

Decomposition:
- Shared package cl_pkg:
  - state enum (OFF, TRAIN, RUN)
  - CL_BITS_PER_WORD=7
  - default CLK_PATTERN, TRAIN_PATTERN and IDLE_WORD constants
- One sub-module, cl_lane_ser: 7-bit parallel-load, MSB-first shift register with load/shift inputs. It is instantiated NUM_LANES+1 times; the clock lane is fed CLK_PATTERN.
- The FSM, bit counter, train counter and handshake live in cl_lvds_tx_ctrl.

Test Plan:
- Reset, then en=1 with TRAIN_WORDS=4 -> ser_clk shows 1100011 repeated from cycle 1; each ser_data lane shows 1010101 x4; trained rises on cycle 29.
- RUN, word_valid held, lane0 word 7'h5A then 7'h33 -> lane0 serial 1011010 then 0110011 with no gap; word_ready high only on bit_cnt==6 cycles.
- RUN, word_valid=0 for one boundary -> lane0 outputs 0000000 for that word, underrun pulses exactly once, ser_clk continues unbroken.
- train_req pulsed for 1 cycle at bit_cnt=2 in RUN -> current word finishes, TRAIN_PATTERN x TRAIN_WORDS follows, trained low throughout, then RUN resumes.
- en dropped at bit_cnt=3 together with train_req -> word completes, OFF entered, all outputs 0, no training started, pending flag cleared.
- rst asserted at bit_cnt=4 in RUN -> all outputs 0 in the same cycle; after release with en=1, a full TRAIN phase runs again from bit_cnt=0.
